nibble_serial_addsub_ctrl: RTL



---
 rtl/nibble_serial_addsub_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-nibble add/subtract sequencer driving an external 4-bit add/sub unit.
// One nibble per clock, carry chained through c_q, flags captured on the last nibble.
module nibble_serial_addsub_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  state_t       state_q, state_d;
  logic [2:0]   k_q, k_d;
  logic         c_q, c_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         sub_q, sub_d;
  logic [W-1:0] res_q, res_d;
  logic         cy_q, cy_d;
  logic         ov_q, ov_d;
  logic         z_q, z_d;

  logic [4:0]   sel;
  logic [3:0]   nib_d;
  logic         b_msb_eff;

  assign sel       = {k_q, 2'b00};
  assign b_msb_eff = sub_q ? ~b_q[W-1] : b_q[W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    z_d     = z_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    nib_d   = sub_q ? ~b_q[sel +: 4] : b_q[sel +: 4];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          k_d     = '0;
          c_d     = sub;
          res_d   = '0;
          cy_d    = 1'b0;
          ov_d    = 1'b0;
          z_d     = 1'b0;
        end
      end
      RUN: begin
        add_a = a_q[sel +: 4];
        add_cin = c_q;
        // Pre-invert by cin so the unit's own b^cin yields nib_d.
        add_b = nib_d ^ {4{c_q}};
        res_d[sel +: 4] = add_sum;
        c_d = add_cout;
        k_d = k_q + 3'd1;
        if (k_q == LAST) begin
          state_d = DONE;
          cy_d    = add_cout;
          ov_d    = (a_q[W-1] == b_msb_eff) &&
                    (add_sum[3] != a_q[W-1]);
          z_d     = (res_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign carry_out = cy_q;
  assign overflow  = ov_q;
  assign zero      = z_q;

endmodule
